// File: rtl/data_mem_bridge.sv
// MEM-stage bridge between the pipeline data-memory port and an external
// request/ack memory bus, with timeout and misalignment detection.
module data_mem_bridge #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_mem_read_enable,
  input  logic        data_mem_write_enable,
  input  logic [31:0] data_mem_read_addr,
  input  logic [31:0] data_mem_write_addr,
  input  logic [31:0] data_mem_write_data,
  output logic [31:0] data_mem_read_data,
  output logic        mem_stall,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        mem_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] rdata_q;

  logic        is_wr;
  logic        is_rd;
  logic        access;
  logic        misaligned;
  logic [31:0] sel_addr;

  always_comb begin
    is_wr      = data_mem_write_enable;
    is_rd      = data_mem_read_enable & ~data_mem_write_enable;
    access     = is_wr | is_rd;
    sel_addr   = is_wr ? data_mem_write_addr : data_mem_read_addr;
    misaligned = |sel_addr[1:0];
  end

  // bus_req comes from state alone, so the bus never sees a path from pipeline inputs
  assign bus_req            = (state == REQ);
  assign mem_stall          = (state == REQ) | ((state == IDLE) & access);
  assign data_mem_read_data = rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      rdata_q   <= '0;
      mem_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (access) begin
            if (misaligned) begin
              state   <= DONE;
              mem_err <= 1'b1;
              rdata_q <= '0;
            end else begin
              state     <= REQ;
              bus_addr  <= sel_addr;
              bus_we    <= is_wr;
              bus_wdata <= is_wr ? data_mem_write_data : '0;
              cnt       <= '0;
            end
          end
        end
        REQ: begin
          if (bus_ack) begin
            state <= DONE;
            if (!bus_we) rdata_q <= bus_rdata;
          end else if (cnt == 8'(TIMEOUT - 1)) begin
            state   <= DONE;
            mem_err <= 1'b1;
            if (!bus_we) rdata_q <= 32'hDEAD_BEEF;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Scoreboard bench for data_mem_bridge: expected completions are queued at
// issue time and compared in the release (DONE) cycle of each access.
module tb_data_mem_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        re, we;
  logic [31:0] raddr, waddr, wdata;
  logic [31:0] read_data;
  logic        mem_stall, bus_req, bus_we, bus_ack, mem_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  data_mem_bridge #(.TIMEOUT(4)) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .data_mem_read_enable  (re),
    .data_mem_write_enable (we),
    .data_mem_read_addr    (raddr),
    .data_mem_write_addr   (waddr),
    .data_mem_write_data   (wdata),
    .data_mem_read_data    (read_data),
    .mem_stall             (mem_stall),
    .bus_req               (bus_req),
    .bus_we                (bus_we),
    .bus_addr              (bus_addr),
    .bus_wdata             (bus_wdata),
    .bus_ack               (bus_ack),
    .bus_rdata             (bus_rdata),
    .mem_err               (mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          stall;
    int          reqs;
    logic        we;
    logic [31:0] wd;
    logic [31:0] addr;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] model_rd  = '0;
  logic        model_err = 1'b0;

  int          ack_delay = 0;
  logic [31:0] ack_data  = '0;
  logic        spurious  = 1'b0;
  int          rc = 0;

  logic        mon_en = 1'b0;
  int          stall_cnt = 0, req_cnt = 0;
  logic        prev_stall = 1'b0;
  logic        cap_we;
  logic [31:0] cap_wd, cap_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // bus responder: ack on REQ cycle number ack_delay (0-based), never when negative
  always @(negedge clk) begin
    if (bus_req) begin
      bus_ack   = (ack_delay >= 0) && (rc == ack_delay);
      bus_rdata = ack_data;
      rc++;
    end else begin
      bus_ack   = spurious;
      bus_rdata = 32'hBAD0_BAD0;
      rc = 0;
    end
  end

  // monitor: a falling stall marks the release cycle of one access
  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_stall) stall_cnt++;
      if (bus_req) begin
        req_cnt++;
        cap_we = bus_we; cap_wd = bus_wdata; cap_addr = bus_addr;
      end
      if (prev_stall && !mem_stall) begin
        if (q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("rdata", read_data, e.rd);
          check("mem_err", {31'd0, mem_err}, {31'd0, e.err});
          check("stall_cycles", stall_cnt, e.stall);
          check("req_cycles", req_cnt, e.reqs);
          if (e.reqs > 0) begin
            check("bus_we", {31'd0, cap_we}, {31'd0, e.we});
            check("bus_wdata", cap_wd, e.wd);
            check("bus_addr", cap_addr, e.addr);
          end
        end
        stall_cnt = 0;
        req_cnt   = 0;
      end
      prev_stall = mem_stall;
    end
  end

  // kind: 0 load, 1 store; dly < 0 means the bus never acks
  task automatic access(input int kind, input logic [31:0] addr, input logic [31:0] d,
                        input int dly);
    exp_t e;
    bit   mis, ok;
    mis = (addr[1:0] != 2'b00);
    ack_delay = dly;
    ack_data  = d;
    e.we = (kind == 1);
    e.wd = (kind == 1) ? d : 32'd0;
    e.addr = addr;
    if (mis) begin
      model_rd = '0; model_err = 1'b1;
      e.reqs = 0; e.stall = 1;
    end else if (dly < 0 || dly > 3) begin
      model_err = 1'b1;
      if (kind == 0) model_rd = 32'hDEAD_BEEF;
      e.reqs = 4; e.stall = 5;
    end else begin
      if (kind == 0) model_rd = d;
      e.reqs = dly + 1; e.stall = dly + 2;
    end
    e.rd  = model_rd;
    e.err = model_err;
    q.push_back(e);
    re = 1'b1;
    we = (kind == 1);
    raddr = (kind == 0) ? addr : 32'h0000_0FF0;
    waddr = (kind == 1) ? addr : 32'h0000_0FF3;
    wdata = d;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!mem_stall) begin ok = 1; break; end
    end
    if (!ok) check("access_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    re = 1'b0; we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; re = 1'b0; we = 1'b0;
    raddr = '0; waddr = '0; wdata = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    #1;
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_bus_we", {31'd0, bus_we}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_rdata", read_data, 32'd0);
    check("rst_mem_err", {31'd0, mem_err}, 32'd0);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    re = 1'b1; #1;
    check("rst_stall_access", {31'd0, mem_stall}, 32'd1);
    re = 1'b0;
    #20; rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;

    access(0, 32'h0000_0100, 32'h1234_5678, 0);
    access(1, 32'h0000_0204, 32'hA5A5_A5A5, 3);
    access(0, 32'h0000_0010, 32'h1111_0010, 1);
    access(0, 32'h0000_0014, 32'h2222_0014, 0);
    for (int i = 0; i < 6; i++)
      access(int'($urandom_range(1, 0)), {$urandom_range(32'hFFFF, 0), 2'b00},
             $urandom, int'($urandom_range(3, 0)));

    // bus_ack outside REQ must not disturb anything
    spurious = 1'b1;
    repeat (3) @(negedge clk);
    check("spurious_req", {31'd0, bus_req}, 32'd0);
    check("spurious_rdata", read_data, model_rd);
    spurious = 1'b0;
    @(negedge clk);

    access(0, 32'h0000_0102, 32'h7777_7777, 0);
    access(0, 32'h0000_0300, 32'h5555_5555, -1);
    access(1, 32'h0000_0308, 32'h0BAD_F00D, -1);
    access(0, 32'h0000_0400, 32'h4040_4040, 0);
    check("err_sticky", {31'd0, mem_err}, 32'd1);

    // reset while a load is waiting on the bus
    mon_en = 1'b0;
    ack_delay = -1;
    re = 1'b1; we = 1'b0; raddr = 32'h0000_0500;
    @(negedge clk); @(negedge clk);
    check("pre_rst_req", {31'd0, bus_req}, 32'd1);
    #2; rst_n = 1'b0; #1;
    check("mid_rst_req", {31'd0, bus_req}, 32'd0);
    check("mid_rst_err", {31'd0, mem_err}, 32'd0);
    check("mid_rst_rdata", read_data, 32'd0);
    re = 1'b0; #1;
    check("mid_rst_stall", {31'd0, mem_stall}, 32'd0);
    @(negedge clk); #2; rst_n = 1'b1;
    model_rd = '0; model_err = 1'b0;
    stall_cnt = 0; req_cnt = 0; prev_stall = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    access(0, 32'h0000_0600, 32'hCAFE_0600, 1);

    repeat (3) @(negedge clk);
    check("queue_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_bridge.md
DATA_MEM_BRIDGE -- requirements
Module: data_mem_bridge

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning the maximum number of cycles spent waiting for bus_ack before the access is abandoned (range 1..255).
REQ-002 clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 data_mem_read_enable  input  1  from the MEM stage; asserted for both loads and stores.
REQ-005 data_mem_write_enable  input  1  from the MEM stage; asserted for stores.
REQ-006 data_mem_read_addr  input  32  load byte address.
REQ-007 data_mem_write_addr  input  32  store byte address.
REQ-008 data_mem_write_data  input  32  store data.
REQ-009 data_mem_read_data  output  32  load result presented to the MEM_WB path.
REQ-010 mem_stall  output  1  freeze request to every pipeline register upstream of, and including, EX_MEM.
REQ-011 bus_req, bus_we  output  1 each  request and write-select to the external memory bus.
REQ-012 bus_addr, bus_wdata  output  32 each  registered bus address and write data.
REQ-013 bus_ack  input  1  completion from memory, sampled each cycle in REQ.
REQ-014 bus_rdata  input  32  read data, valid in the cycle bus_ack=1.
REQ-015 mem_err  output  1  sticky error flag, set by a timeout or a misaligned access.

Function
REQ-016 Access classification: write = data_mem_write_enable; read = data_mem_read_enable AND NOT data_mem_write_enable; none otherwise.
REQ-017 Alignment: an access is misaligned when bits [1:0] of the selected address are non-zero (write_addr for writes, read_addr for reads).
REQ-018 FSM states: IDLE, REQ, DONE; a 2-bit state register.
REQ-019 IDLE, aligned access -> REQ; capture bus_addr, bus_we and bus_wdata (write data for writes, 0 for reads); clear the timeout counter.
REQ-020 IDLE, misaligned access -> DONE without any bus transaction; set mem_err; load the read-data register with 0.
REQ-021 IDLE, no access -> IDLE; no bus activity.
REQ-022 REQ: bus_req=1; bus_ack=1 -> DONE, and a read captures bus_rdata into the read-data register (a write leaves it unchanged).
REQ-023 REQ: bus_ack=0 -> increment the counter; when the counter reaches TIMEOUT-1 with no ack -> DONE, set mem_err, and a read loads 32'hDEADBEEF.
REQ-024 DONE -> IDLE unconditionally; bus_req=0.
REQ-025 mem_stall is combinational: 1 in IDLE when an access is requested, 1 in REQ, 0 in DONE and in idle IDLE.
REQ-026 Latency: an aligned access acked on its first REQ cycle stalls for exactly 2 cycles; DONE is the release cycle in which EX_MEM advances.
REQ-027 data_mem_read_data is driven from the read-data register and holds its value until the next completed read.
REQ-028 bus_req is decoded from state only, so it has no combinational path from the inputs.
REQ-029 bus_ack while not in REQ is ignored.
REQ-030 mem_err stays set until reset.
REQ-031 The access present in DONE is never re-issued; the following access starts from IDLE on the next cycle.

Reset
REQ-032 While rst_n=0: state=IDLE, counter=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, read-data register=0, mem_err=0, and mem_stall follows REQ-025 with state=IDLE.
REQ-033 Reset asserted mid-transaction drops bus_req immediately and abandons the access; no data is captured.

Verification
REQ-034 Aligned load addr 0x100, ack on the 1st REQ cycle with rdata 0x12345678 -> mem_stall high for 2 cycles, bus_req high for 1 cycle, read_data=0x12345678 in DONE.
REQ-035 Store addr 0x204, data 0xA5A5A5A5 (read_enable=1 and write_enable=1), ack after 3 cycles -> bus_we=1, bus_wdata=0xA5A5A5A5, stall for 5 cycles, read_data unchanged.
REQ-036 Load addr 0x102 -> no bus_req, mem_err=1, read_data=0, stall for 1 cycle.
REQ-037 Load with TIMEOUT=4 and no ack -> bus_req high for 4 cycles, then DONE with read_data=0xDEADBEEF and mem_err=1.
REQ-038 Back-to-back loads 0x10 then 0x14 -> two separate bus transactions, IDLE visited between them, no duplicate request.
REQ-039 rst_n pulsed low during REQ -> bus_req=0 asynchronously, state IDLE, mem_err=0; a subsequent load completes normally.
